rst_sync_seq: RTL and testbench



---
 rtl/rst_seq_pkg.sv | 16 +
 rtl/rst_sync_chain.sv | 24 ++
 rtl/rst_sync_seq.sv | 118 +++++++++++
 tb/tb_rst_sync_seq.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared constants for the staged reset sequencer:
// FSM state encoding and counter sizing helper.
package rst_seq_pkg;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Bits needed to count up to the larger of two limits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Async-assert / sync-deassert reset synchroniser.
// RST_SYNC rises NUM_STAGES edges after RST releases.
module rst_sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic RST_SYNC
);

  logic [NUM_STAGES-1:0] sync_q;
  logic [NUM_STAGES-1:0] sync_d;

  assign sync_d = {sync_q[NUM_STAGES-2:0], 1'b1};

  // Shift ones in once RST is high; clear at once when it drops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  assign RST_SYNC = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_sync_seq.sv
// Reset synchroniser plus staged release of NUM_CH
// downstream resets, with a synchronous soft-reset replay.
module rst_sync_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 4,
  parameter int MIN_ASSERT  = 4,
  parameter int RELEASE_GAP = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic              RST_SYNC,
  output logic [NUM_CH-1:0] RST_OUT,
  output logic              SEQ_DONE
);

  localparam int CW = cnt_width(MIN_ASSERT, RELEASE_GAP);
  localparam int IW = $clog2(NUM_CH + 1);

  logic              sync;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic              done_q, done_d;

  rst_sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_chain (
    .CLK      (CLK),
    .RST      (RST),
    .RST_SYNC (sync)
  );

  // Sequencer next state: hold, then release one channel per gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    done_d  = done_q;
    if (SW_RST_REQ) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (sync) begin
            if (cnt_q == CW'(MIN_ASSERT - 1)) begin
              out_d = NUM_CH'(1);
              idx_d = IW'(1);
              cnt_d = '0;
              if (NUM_CH == 1) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_RELEASE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt_q == CW'(RELEASE_GAP - 1)) begin
            out_d = (out_q << 1) | NUM_CH'(1);
            idx_d = idx_q + 1'b1;
            cnt_d = '0;
            if (idx_q == IW'(NUM_CH - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          out_d  = '1;
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // Sequencer registers, all cleared directly by RST.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign RST_SYNC = sync;
  assign RST_OUT  = out_q;
  assign SEQ_DONE = done_q;

endmodule

// File: tb/tb_rst_sync_seq.sv
// Bench for rst_sync_seq: default build plus a
// (3,1,1,1) build, checked against edge-count arithmetic.
module tb_rst_sync_seq;

  localparam int NS  = 2;
  localparam int NCH = 4;
  localparam int MA  = 4;
  localparam int GAP = 2;
  localparam int NS6 = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic SW  = 1'b0;
  logic sync_a, done_a;
  logic [3:0] out_a;

  logic RST6 = 1'b1;
  logic SW6  = 1'b0;
  logic sync_b, done_b;
  logic [0:0] out_b;

  int checks = 0;
  int errors = 0;

  // Edges since RST release, and the edge the hold window starts from.
  int k_a  = 0;
  int t0_a = NS;
  int k_b  = 0;
  int t0_b = NS6;

  always #5 CLK = ~CLK;

  rst_sync_seq #(
    .NUM_STAGES(NS), .NUM_CH(NCH),
    .MIN_ASSERT(MA), .RELEASE_GAP(GAP)
  ) dut (
    .CLK(CLK), .RST(RST), .SW_RST_REQ(SW),
    .RST_SYNC(sync_a), .RST_OUT(out_a), .SEQ_DONE(done_a)
  );

  rst_sync_seq #(
    .NUM_STAGES(NS6), .NUM_CH(1),
    .MIN_ASSERT(1), .RELEASE_GAP(1)
  ) dut6 (
    .CLK(CLK), .RST(RST6), .SW_RST_REQ(SW6),
    .RST_SYNC(sync_b), .RST_OUT(out_b), .SEQ_DONE(done_b)
  );

  // A soft request only counts once the synchronised reset is up.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      k_a  <= 0;
      t0_a <= NS;
    end else begin
      k_a <= k_a + 1;
      if (SW && (k_a + 1 > NS)) t0_a <= k_a + 1;
    end
  end

  always @(posedge CLK or negedge RST6) begin
    if (!RST6) begin
      k_b  <= 0;
      t0_b <= NS6;
    end else begin
      k_b <= k_b + 1;
      if (SW6 && (k_b + 1 > NS6)) t0_b <= k_b + 1;
    end
  end

  // Channel i is free once MA + i*GAP edges passed since t0.
  function automatic logic [31:0] exp_bits(
    input int k, input int t0, input int nch,
    input int ma, input int gap
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nch; i++)
      r[i] = (k >= t0 + ma + i * gap);
    return r;
  endfunction

  logic [3:0] pv_a;
  logic       gate_a;
  logic [0:0] pv_b;
  logic       gate_b;

  // Released bits may only drop through RST or a soft request.
  always @(posedge CLK) begin
    pv_a   = out_a;
    gate_a = RST && !SW;
    pv_b   = out_b;
    gate_b = RST6 && !SW6;
    #1;
    if (gate_a && RST) begin
      checks++;
      if ((pv_a & ~out_a) !== 4'b0000) begin
        errors++;
        $display("FAIL mono_a: was %b now %b", pv_a, out_a);
      end
    end
    if (gate_b && RST6) begin
      checks++;
      if ((pv_b & ~out_b) !== 1'b0) begin
        errors++;
        $display("FAIL mono_b: was %b now %b", pv_b, out_b);
      end
    end
  end

  task automatic test_reset();
    #1;
    RST  = 1'b0;
    RST6 = 1'b0;
    #1;
    checks++;
    if ({sync_a, done_a, out_a} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async: got %b want 000000",
               {sync_a, done_a, out_a});
    end
    for (int n = 0; n < 3; n++) begin
      @(posedge CLK); #1;
      checks++;
      if ({sync_a, done_a, out_a} !== 6'b0) begin
        errors++;
        $display("FAIL reset_hold: got %b want 000000",
                 {sync_a, done_a, out_a});
      end
    end
  endtask

  task automatic test_power_on();
    logic [31:0] eb;
    logic [5:0]  ev;
    logic [3:0]  tbl [4];
    tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    @(negedge CLK);
    RST = 1'b1;
    SW  = 1'b1;
    for (int n = 0; n < 14; n++) begin
      @(posedge CLK); #1;
      eb = exp_bits(k_a, t0_a, NCH, MA, GAP);
      ev = {k_a >= NS, eb[NCH-1], eb[3:0]};
      checks++;
      if ({sync_a, done_a, out_a} !== ev) begin
        errors++;
        $display("FAIL power_on e%0d: got %b want %b",
                 k_a, {sync_a, done_a, out_a}, ev);
      end
      if (k_a >= 6 && k_a <= 12 && k_a % 2 == 0) begin
        checks++;
        if (out_a !== tbl[(k_a - 6) / 2]) begin
          errors++;
          $display("FAIL power_on_edge e%0d: got %b want %b",
                   k_a, out_a, tbl[(k_a - 6) / 2]);
        end
      end
      @(negedge CLK);
      if (k_a >= 1) SW = 1'b0;
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL power_on_done: got %b want 1", done_a);
    end
  endtask

  task automatic test_soft_done();
    logic [31:0] eb;
    logic [5:0]  ev;
    int e;
    SW = 1'b1;
    @(posedge CLK); #1;
    e = k_a;
    checks++;
    if ({sync_a, done_a, out_a} !== 6'b100000) begin
      errors++;
      $display("FAIL soft_done_clear: got %b want 100000",
               {sync_a, done_a, out_a});
    end
    @(negedge CLK);
    SW = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge CLK); #1;
      eb = exp_bits(k_a, t0_a, NCH, MA, GAP);
      ev = {1'b1, eb[NCH-1], eb[3:0]};
      checks++;
      if ({sync_a, done_a, out_a} !== ev) begin
        errors++;
        $display("FAIL soft_done e%0d: got %b want %b",
                 k_a, {sync_a, done_a, out_a}, ev);
      end
      if (k_a == e + 4) begin
        checks++;
        if (out_a !== 4'b0001) begin
          errors++;
          $display("FAIL soft_done_ch0: got %b want 0001", out_a);
        end
      end
      if (k_a == e + 10) begin
        checks++;
        if ({done_a, out_a} !== 5'b11111) begin
          errors++;
          $display("FAIL soft_done_ch3: got %b want 11111",
                   {done_a, out_a});
        end
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_async_pulse();
    logic [31:0] eb;
    logic [5:0]  ev;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({sync_a, done_a, out_a} !== 6'b0) begin
      errors++;
      $display("FAIL async_pulse: got %b want 000000",
               {sync_a, done_a, out_a});
    end
    @(negedge CLK);
    RST = 1'b1;
    while (k_a < 8) begin
      @(posedge CLK); #1;
      eb = exp_bits(k_a, t0_a, NCH, MA, GAP);
      ev = {k_a >= NS, eb[NCH-1], eb[3:0]};
      checks++;
      if ({sync_a, done_a, out_a} !== ev) begin
        errors++;
        $display("FAIL replay e%0d: got %b want %b",
                 k_a, {sync_a, done_a, out_a}, ev);
      end
    end
    checks++;
    if (out_a !== 4'b0011) begin
      errors++;
      $display("FAIL replay_e8: got %b want 0011", out_a);
    end
  endtask

  task automatic test_soft_mid();
    logic [31:0] eb;
    logic [5:0]  ev;
    logic [3:0]  tbl [4];
    tbl = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    @(negedge CLK);
    SW = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({done_a, out_a} !== 5'b0) begin
      errors++;
      $display("FAIL soft_mid_clear e%0d: got %b want 00000",
               k_a, {done_a, out_a});
    end
    while (k_a < 19) begin
      @(negedge CLK);
      SW = 1'b0;
      @(posedge CLK); #1;
      eb = exp_bits(k_a, t0_a, NCH, MA, GAP);
      ev = {1'b1, eb[NCH-1], eb[3:0]};
      checks++;
      if ({sync_a, done_a, out_a} !== ev) begin
        errors++;
        $display("FAIL soft_mid e%0d: got %b want %b",
                 k_a, {sync_a, done_a, out_a}, ev);
      end
      if (k_a >= 13 && k_a % 2 == 1) begin
        checks++;
        if (out_a !== tbl[(k_a - 13) / 2]) begin
          errors++;
          $display("FAIL soft_mid_edge e%0d: got %b want %b",
                   k_a, out_a, tbl[(k_a - 13) / 2]);
        end
      end
    end
  endtask

  task automatic test_soft_hold();
    logic [31:0] eb;
    logic [5:0]  ev;
    while (k_a < 40) begin
      @(negedge CLK);
      SW = (k_a >= 19 && k_a <= 28);
      @(posedge CLK); #1;
      eb = exp_bits(k_a, t0_a, NCH, MA, GAP);
      ev = {1'b1, eb[NCH-1], eb[3:0]};
      checks++;
      if ({sync_a, done_a, out_a} !== ev) begin
        errors++;
        $display("FAIL soft_hold e%0d: got %b want %b",
                 k_a, {sync_a, done_a, out_a}, ev);
      end
      if (k_a >= 20 && k_a <= 32) begin
        checks++;
        if (out_a !== 4'b0000) begin
          errors++;
          $display("FAIL soft_hold_low e%0d: got %b want 0000",
                   k_a, out_a);
        end
      end
      if (k_a == 33) begin
        checks++;
        if (out_a !== 4'b0001) begin
          errors++;
          $display("FAIL soft_hold_ch0: got %b want 0001", out_a);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] eb;
    logic [5:0]  ev;
    int hold;
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (hold > 0) begin
        hold--;
      end else begin
        SW = ($urandom_range(0, 9) == 0);
        if (SW && $urandom_range(0, 3) == 0)
          hold = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 79) == 0) begin
        #2;
        RST = 1'b0;
        #2;
        RST = 1'b1;
      end
      @(posedge CLK); #1;
      eb = exp_bits(k_a, t0_a, NCH, MA, GAP);
      ev = {k_a >= NS, eb[NCH-1], eb[3:0]};
      checks++;
      if ({sync_a, done_a, out_a} !== ev) begin
        errors++;
        $display("FAIL random e%0d: got %b want %b",
                 k_a, {sync_a, done_a, out_a}, ev);
      end
    end
    @(negedge CLK);
    SW = 1'b0;
  endtask

  task automatic test_params();
    logic [31:0] eb;
    logic [2:0]  ev;
    checks++;
    if ({sync_b, done_b, out_b} !== 3'b0) begin
      errors++;
      $display("FAIL params_reset: got %b want 000",
               {sync_b, done_b, out_b});
    end
    @(negedge CLK);
    RST6 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge CLK); #1;
      eb = exp_bits(k_b, t0_b, 1, 1, 1);
      ev = {k_b >= NS6, eb[0], eb[0]};
      checks++;
      if ({sync_b, done_b, out_b} !== ev) begin
        errors++;
        $display("FAIL params e%0d: got %b want %b",
                 k_b, {sync_b, done_b, out_b}, ev);
      end
      if (k_b == 3 || k_b == 4) begin
        checks++;
        if ({done_b, out_b} !== {2{k_b == 4}}) begin
          errors++;
          $display("FAIL params_edge e%0d: got %b",
                   k_b, {done_b, out_b});
        end
      end
      @(negedge CLK);
      SW6 = (k_b >= 8) && ($urandom_range(0, 2) == 0);
    end
    SW6 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft_done();
    test_async_pulse();
    test_soft_mid();
    test_soft_hold();
    test_random();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
